// File: rtl/led_scan_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : led_scan_if
// Brief    : Value-source / display-side bundle for the LED scan scheduler.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface led_scan_if;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic        frame_start;
  logic        an3;
  logic        an2;
  logic        an1;
  logic        an0;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        dp;

  modport master (
    output digits_in, dp_in, load,
    input  load_ack, frame_start, an3, an2, an1, an0, digit_sel, nibble, dp
  );

  modport slave (
    input  digits_in, dp_in, load,
    output load_ack, frame_start, an3, an2, an1, an0, digit_sel, nibble, dp
  );
endinterface
`default_nettype wire

// File: rtl/led_scan_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : led_scan_scheduler
// Brief    : Four-digit anode scan with inter-digit blanking and a
//            double-buffered display word committed at frame boundaries.
// Revision : 1.0
// ---------------------------------------------------------------------------
module led_scan_scheduler #(
  parameter int ON_CYCLES    = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  wire logic   clk,
  input  wire logic   reset,
  led_scan_if.slave   bus
);

  localparam int c_max_cycles = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
  localparam logic [c_cnt_w-1:0] c_on_last    = c_cnt_w'(ON_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_started;
  logic               r_pending;
  logic [15:0]        r_stage_digits;
  logic [3:0]         r_stage_dp;
  logic [15:0]        r_shadow_digits;
  logic [3:0]         r_shadow_dp;
  logic [3:0]         r_an;
  logic [1:0]         r_sel;
  logic [3:0]         r_nibble;
  logic               r_dp;
  logic               r_frame_start;
  logic               r_load_ack;

  logic               w_blank_entry;
  logic [1:0]         w_next_sel;
  logic               w_commit;
  logic [15:0]        w_shadow_digits_nxt;
  logic [3:0]         w_shadow_dp_nxt;
  logic [3:0]         w_nibble_nxt;
  logic               w_dp_nxt;

  // The first clock after reset is treated as a BLANK entry for digit 3 so
  // that it is a frame boundary like any other.
  assign w_blank_entry = !r_started || ((r_state == ST_ON) && (r_cnt == c_on_last));
  assign w_next_sel    = r_started ? (r_sel - 2'd1) : 2'd3;
  assign w_commit      = w_blank_entry && (w_next_sel == 2'd3);

  always_comb begin
    w_shadow_digits_nxt = r_shadow_digits;
    w_shadow_dp_nxt     = r_shadow_dp;
    if (w_commit) begin
      if (bus.load) begin
        w_shadow_digits_nxt = bus.digits_in;
        w_shadow_dp_nxt     = bus.dp_in;
      end else if (r_pending) begin
        w_shadow_digits_nxt = r_stage_digits;
        w_shadow_dp_nxt     = r_stage_dp;
      end
    end
  end

  assign w_nibble_nxt = w_shadow_digits_nxt[{w_next_sel, 2'b00} +: 4];
  assign w_dp_nxt     = ~w_shadow_dp_nxt[w_next_sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_BLANK;
      r_cnt           <= '0;
      r_started       <= 1'b0;
      r_pending       <= 1'b0;
      r_stage_digits  <= '0;
      r_stage_dp      <= '0;
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
      r_an            <= 4'hF;
      r_sel           <= 2'd3;
      r_nibble        <= 4'h0;
      r_dp            <= 1'b1;
      r_frame_start   <= 1'b0;
      r_load_ack      <= 1'b0;
    end else begin
      r_started       <= 1'b1;
      r_load_ack      <= bus.load;
      r_frame_start   <= w_commit;
      r_shadow_digits <= w_shadow_digits_nxt;
      r_shadow_dp     <= w_shadow_dp_nxt;
      r_pending       <= (bus.load || r_pending) && !w_commit;
      if (bus.load) begin
        r_stage_digits <= bus.digits_in;
        r_stage_dp     <= bus.dp_in;
      end

      if (w_blank_entry) begin
        r_state  <= ST_BLANK;
        r_cnt    <= '0;
        r_an     <= 4'hF;
        r_sel    <= w_next_sel;
        r_nibble <= w_nibble_nxt;
        r_dp     <= w_dp_nxt;
      end else if (r_state == ST_BLANK) begin
        if (r_cnt == c_blank_last) begin
          r_state <= ST_ON;
          r_cnt   <= '0;
          r_an    <= ~(4'b0001 << r_sel);
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign bus.an3         = r_an[3];
  assign bus.an2         = r_an[2];
  assign bus.an1         = r_an[1];
  assign bus.an0         = r_an[0];
  assign bus.digit_sel   = r_sel;
  assign bus.nibble      = r_nibble;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame_start;
  assign bus.load_ack    = r_load_ack;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_led_scan_scheduler
// Brief    : Self-checking bench for led_scan_scheduler against a position-in-frame model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_led_scan_scheduler;

  localparam int ON    = 16;
  localparam int BLANK = 2;
  localparam int SLOT  = ON + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  led_scan_if bus();

  led_scan_scheduler #(.ON_CYCLES(ON), .BLANK_CYCLES(BLANK)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every output is a function of the clock's position within the frame
  // plus the shadow word chosen at the most recent frame boundary.
  int          e = 0;
  logic        m_pending = 1'b0;
  logic [15:0] m_stage = '0, m_shadow = '0;
  logic [3:0]  m_stage_dp = '0, m_shadow_dp = '0;
  logic [3:0]  exp_an = 4'hF, exp_nib = 4'h0;
  logic [1:0]  exp_sel = 2'd3;
  logic        exp_dp = 1'b1, exp_fs = 1'b0, exp_ack = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int pos, slot, sub, digit;
    if (!rst_n) begin
      e = 0; m_pending = 1'b0;
      m_stage = '0; m_shadow = '0; m_stage_dp = '0; m_shadow_dp = '0;
      exp_an = 4'hF; exp_sel = 2'd3; exp_nib = 4'h0; exp_dp = 1'b1;
      exp_fs = 1'b0; exp_ack = 1'b0;
    end else begin
      pos = e % FRAME;
      exp_ack = bus.load;
      if (pos == 0) begin
        if (bus.load) begin
          m_shadow = bus.digits_in; m_shadow_dp = bus.dp_in;
        end else if (m_pending) begin
          m_shadow = m_stage; m_shadow_dp = m_stage_dp;
        end
        m_pending = 1'b0;
      end
      if (bus.load) begin
        m_stage = bus.digits_in; m_stage_dp = bus.dp_in;
        if (pos != 0) m_pending = 1'b1;
      end
      slot  = pos / SLOT;
      sub   = pos % SLOT;
      digit = 3 - slot;
      exp_fs  = (pos == 0);
      exp_sel = digit[1:0];
      exp_an  = (sub < BLANK) ? 4'hF : ~(4'b0001 << digit);
      exp_nib = m_shadow[digit*4 +: 4];
      exp_dp  = ~m_shadow_dp[digit];
      e++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] an;
    if (rst_n) begin
      an = {bus.an3, bus.an2, bus.an1, bus.an0};
      check("anodes", 32'(an), 32'(exp_an));
      check("digit_sel", 32'(bus.digit_sel), 32'(exp_sel));
      check("nibble", 32'(bus.nibble), 32'(exp_nib));
      check("dp", 32'(bus.dp), 32'(exp_dp));
      check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
      check("load_ack", 32'(bus.load_ack), 32'(exp_ack));
      check("anode_overlap", 32'($countones(~an) <= 1), 32'd1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fs();
    int k;
    for (k = 0; k < 2 * FRAME; k++) begin
      tick();
      if (bus.frame_start) break;
    end
    check("frame_start_timeout", 32'(bus.frame_start), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.load = 1'b1; bus.digits_in = d; bus.dp_in = p;
    tick();
    bus.load = 1'b0;
    check("load_ack_pulse", 32'(bus.load_ack), 32'd1);
  endtask

  function automatic logic [3:0] anodes();
    return {bus.an3, bus.an2, bus.an1, bus.an0};
  endfunction

  initial begin
    logic [3:0] exp_nibs [4];
    logic       exp_dps [4];
    bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;

    // Reset values and first frame timing
    #100;
    @(posedge clk); #1;
    check("reset_anodes", 32'(anodes()), 32'hF);
    check("reset_sel", 32'(bus.digit_sel), 32'd3);
    check("reset_dp", 32'(bus.dp), 32'd1);
    check("reset_fs", 32'(bus.frame_start), 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_fs", 32'(bus.frame_start), 32'd1);
    check("first_blank", 32'(anodes()), 32'hF);
    tick(2);
    check("an3_on", 32'(anodes()), 32'b0111);
    check("idle_nibble", 32'(bus.nibble), 32'h0);
    tick(16);
    check("blank_before_d2", 32'(anodes()), 32'hF);
    check("sel_d2", 32'(bus.digit_sel), 32'd2);
    tick(2);
    check("an2_on", 32'(anodes()), 32'b1011);

    // Mid-frame load is held until the next frame boundary
    tick(10);
    do_load(16'h1234, 4'b0001);
    check("no_tear_nibble", 32'(bus.nibble), 32'h0);
    wait_fs();
    exp_nibs = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp_dps  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tick(2);
    for (int k = 0; k < 4; k++) begin
      check("frame_1234_nibble", 32'(bus.nibble), 32'(exp_nibs[k]));
      check("frame_1234_dp", 32'(bus.dp), 32'(exp_dps[k]));
      tick(SLOT);
    end

    // Back-to-back loads: last one wins
    tick(5);
    do_load(16'hAAAA, 4'b0000);
    do_load(16'h5555, 4'b0000);
    wait_fs();
    tick(2);
    check("last_load_wins", 32'(bus.nibble), 32'h5);

    // Load coincident with the boundary bypasses staging
    tick(FRAME - 3);
    bus.load = 1'b1; bus.digits_in = 16'hBEEF; bus.dp_in = 4'b0000;
    tick();
    bus.load = 1'b0;
    check("bypass_fs", 32'(bus.frame_start), 32'd1);
    check("bypass_nibble", 32'(bus.nibble), 32'hB);
    check("bypass_ack", 32'(bus.load_ack), 32'd1);

    // Asynchronous reset in the middle of digit 1
    tick(43);
    check("an1_on", 32'(anodes()), 32'b1101);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_anodes", 32'(anodes()), 32'hF);
    check("async_reset_sel", 32'(bus.digit_sel), 32'd3);
    check("async_reset_nibble", 32'(bus.nibble), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick();
    check("restart_fs", 32'(bus.frame_start), 32'd1);
    tick(2);
    check("restart_an3", 32'(anodes()), 32'b0111);
    check("restart_shadow", 32'(bus.nibble), 32'h0);

    // Random loads over ten frames
    for (int i = 0; i < 10 * FRAME; i++) begin
      bus.load      = ($urandom_range(0, 7) == 0);
      bus.digits_in = 16'($urandom);
      bus.dp_in     = 4'($urandom_range(0, 15));
      tick();
    end
    bus.load = 1'b0;
    tick(FRAME + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
